// File: rtl/sisr_bist_ctrl.sv
// BIST sequencer around a 4-bit serial-input signature register: clears the
// SISR, compacts NBITS accepted stream bits, then compares against a golden value.
module sisr_bist_ctrl #(
  parameter int NBITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] golden,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    SHIFT   = 2'd2,
    COMPARE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_bit;
  logic [3:0]    sig_next;

  assign din_ready = (state == SHIFT);
  assign busy      = (state != IDLE);

  // An abort in the same cycle as a presented bit must keep that bit out of the signature.
  assign accept   = din_ready & din_valid & ~abort;
  assign last_bit = (cnt == CW'(NBITS - 1));

  // Feedback taps: q3 folds back into q0 and q1.
  assign sig_next = {sig[2], sig[1], sig[0] ^ sig[3], din ^ sig[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig   <= 4'b0000;
      cnt   <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end

        CLEAR: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            sig   <= 4'b0000;
            cnt   <= '0;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (accept) begin
            sig <= sig_next;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
              state <= COMPARE;
            end
          end
        end

        COMPARE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            pass  <= (sig == golden);
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisr_bist_ctrl.sv
// Directed bench for sisr_bist_ctrl: three instances (NBITS = 4, 5, 16) share
// one stimulus set; each scenario resets everything and then observes one instance.
module tb_sisr_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] golden;
  logic       din;
  logic       din_valid;

  logic       ready4, busy4, done4, pass4;
  logic [3:0] sig4;
  logic       ready5, busy5, done5, pass5;
  logic [3:0] sig5;
  logic       ready16, busy16, done16, pass16;
  logic [3:0] sig16;

  int passed;
  int total;

  sisr_bist_ctrl #(.NBITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
    .din(din), .din_valid(din_valid), .din_ready(ready4), .busy(busy4),
    .done(done4), .pass(pass4), .sig(sig4)
  );

  sisr_bist_ctrl #(.NBITS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
    .din(din), .din_valid(din_valid), .din_ready(ready5), .busy(busy5),
    .done(done5), .pass(pass5), .sig(sig5)
  );

  sisr_bist_ctrl #(.NBITS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
    .din(din), .din_valid(din_valid), .din_ready(ready16), .busy(busy16),
    .done(done16), .pass(pass16), .sig(sig16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic d, input logic v);
    start     = s;
    abort     = a;
    din       = d;
    din_valid = v;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq1 [4];
    logic [3:0] exp4 [4];
    passed = 0;
    total  = 0;
    golden = 4'b1000;
    rst    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- Reset state ----------------
    doReset();
    checkOutput("rst_sig",   {4'h0, sig4},  8'h00);
    checkOutput("rst_done",  {7'h0, done4}, 8'h00);
    checkOutput("rst_pass",  {7'h0, pass4}, 8'h00);
    checkOutput("rst_ready", {7'h0, ready4}, 8'h00);
    checkOutput("rst_busy",  {7'h0, busy4}, 8'h00);

    // ---------------- Scenario 1: NBITS=4, stream 1,0,0,0 ----------------
    seq1[0] = 4'd1; seq1[1] = 4'd0; seq1[2] = 4'd0; seq1[3] = 4'd0;
    exp4[0] = 4'b0001; exp4[1] = 4'b0010; exp4[2] = 4'b0100; exp4[3] = 4'b1000;
    golden = 4'b1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 0: start sampled
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s1_clear_busy",  {7'h0, busy4},  8'h01);
    checkOutput("s1_clear_ready", {7'h0, ready4}, 8'h00);
    tick();                                  // edge 1: CLEAR -> SHIFT
    checkOutput("s1_shift_sig", {4'h0, sig4}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("s1_ready_%0d", i), {7'h0, ready4}, 8'h01);
      applyStimulus(1'b0, 1'b0, seq1[i][0], 1'b1);
      tick();                                // edges 2..5
      checkOutput($sformatf("s1_sig_%0d", i), {4'h0, sig4}, {4'h0, exp4[i]});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_ready_off", {7'h0, ready4}, 8'h00);
    checkOutput("s1_done_e5",   {7'h0, done4},  8'h00);
    tick();                                  // edge 6
    checkOutput("s1_done_e6", {7'h0, done4}, 8'h01);
    checkOutput("s1_pass_e6", {7'h0, pass4}, 8'h01);
    checkOutput("s1_busy_e6", {7'h0, busy4}, 8'h00);

    // ---------------- Scenario 2: NBITS=5, stream 1,0,0,0,0 ----------------
    doReset();
    golden = 4'b1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 0), 1'b1);
      tick();
    end
    checkOutput("s2_sig", {4'h0, sig5}, 8'h03);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s2_done", {7'h0, done5}, 8'h01);
    checkOutput("s2_pass", {7'h0, pass5}, 8'h00);
    checkOutput("s2_sig_hold", {4'h0, sig5}, 8'h03);

    // ---------------- Scenario 3: NBITS=4 with a 3-cycle stall ----------------
    doReset();
    golden = 4'b1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 1
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();                                  // edge 2: bit 1
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();                                  // edge 3: bit 2
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();                                // edges 4..6: stall
      checkOutput($sformatf("s3_stall_sig_%0d", i), {4'h0, sig4}, 8'h02);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();                                  // edge 7: bit 3
    tick();                                  // edge 8: bit 4
    checkOutput("s3_sig",     {4'h0, sig4},  8'h08);
    checkOutput("s3_done_e8", {7'h0, done4}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 9
    checkOutput("s3_done_e9", {7'h0, done4}, 8'h01);
    checkOutput("s3_pass",    {7'h0, pass4}, 8'h01);

    // ---------------- Scenario 4: NBITS=16 start-while-busy and abort ----------------
    doReset();
    golden = 4'b0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); tick();   // 0001
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); tick();   // 0010
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); tick();   // 0101
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); tick();   // 1011
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); tick();   // 0101
    checkOutput("s4_sig5", {4'h0, sig16}, 8'h05);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s4_start_ignored_busy", {7'h0, busy16}, 8'h01);
    checkOutput("s4_start_ignored_sig",  {4'h0, sig16},  8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_abort_busy",  {7'h0, busy16},  8'h00);
    checkOutput("s4_abort_done",  {7'h0, done16},  8'h00);
    checkOutput("s4_abort_ready", {7'h0, ready16}, 8'h00);
    checkOutput("s4_abort_sig",   {4'h0, sig16},   8'h05);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("s4_restart_sig", {4'h0, sig16}, 8'h00);

    // ---------------- Scenario 5: async reset between edges ----------------
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); tick();   // 0001
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); tick();   // 0011
    checkOutput("s5_pre_sig", {4'h0, sig16}, 8'h03);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s5_async_sig",   {4'h0, sig16},   8'h00);
    checkOutput("s5_async_done",  {7'h0, done16},  8'h00);
    checkOutput("s5_async_pass",  {7'h0, pass16},  8'h00);
    checkOutput("s5_async_ready", {7'h0, ready16}, 8'h00);
    rst = 1'b0;

    // ---------------- Scenario 6: NBITS=16 all zeros, then restart ----------------
    doReset();
    golden = 4'b0000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      tick();                                // edges 1..17
    end
    checkOutput("s6_sig_zero", {4'h0, sig16},  8'h00);
    checkOutput("s6_done_e17", {7'h0, done16}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();                                  // edge 18
    checkOutput("s6_done_e18", {7'h0, done16}, 8'h01);
    checkOutput("s6_pass_e18", {7'h0, pass16}, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6_restart_done", {7'h0, done16}, 8'h00);
    checkOutput("s6_restart_busy", {7'h0, busy16}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sisr_bist_ctrl.md
Name: sisr_bist_ctrl

Overview:
- Sequencer and checker for the 4-bit serial-input signature register (SISR).
- On a start request it clears the signature, then compacts exactly NBITS serial bits from a valid/ready stream. It compares the result against a golden value and reports pass/fail.
- Sits between a BIST pattern source and the test-status logic.
- Contains its own 4-bit SISR with the team's standard feedback (see Behaviour).

Parameters:
- NBITS, 16, number of serial bits compacted per run; legal range 1..65535.
- CW, $clog2(NBITS+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancel the current run; honoured in any non-IDLE state.
- golden  input  4  expected signature; sampled in COMPARE.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  controller accepts din this cycle.
- busy  output  1  run in progress (state != IDLE).
- done  output  1  run finished; sticky until the next accepted start.
- pass  output  1  signature matched golden; meaningful only while done=1.
- sig  output  4  current signature register contents.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sig=0, cnt=0, done=0, pass=0.
  - din_ready=0, busy=0.
  - Reset takes effect immediately and overrides everything, including mid-run.
- SISR update, applied only on an accept (din_ready & din_valid, rising edge):
  - q0' = din ^ q3
  - q1' = q0 ^ q3
  - q2' = q1
  - q3' = q2
- Bit ordering: the first accepted bit is the first bit of the stream.
- States: IDLE, CLEAR, SHIFT, COMPARE.
- IDLE:
  - busy=0, din_ready=0; sig, done and pass hold.
  - start=1 -> CLEAR, with done<=0, pass<=0.
- CLEAR (1 cycle):
  - busy=1, din_ready=0.
  - sig<=0, cnt<=0, then -> SHIFT.
- SHIFT:
  - busy=1, din_ready=1 (combinational from state).
  - On accept: shift the SISR and cnt<=cnt+1.
  - If the accepted bit is bit number NBITS (cnt==NBITS-1 before the edge) -> COMPARE.
  - din_valid=0: no shift, cnt holds; stalls are unbounded.
- COMPARE (1 cycle):
  - busy=1, din_ready=0.
  - pass<=(sig==golden), done<=1, -> IDLE.
  - sig holds its final value after the run.
- Latency: with din_valid held high, done rises on the (NBITS+2)th rising edge after the edge that samples start.
- Simultaneous events:
  - abort and rst both high: rst wins.
  - abort=1 in CLEAR/SHIFT/COMPARE: -> IDLE next edge.
    - The bit presented that cycle is not accepted.
    - done=0, pass=0; sig keeps its partial value.
  - abort in COMPARE also suppresses done.
  - abort in IDLE has no effect.
  - start while busy is ignored, with no queuing.
  - start and abort in the same IDLE cycle: start wins (abort is ignored in IDLE).
- Back-to-back: start may be asserted in the first IDLE cycle after COMPARE.
  - The new run clears done/pass on that edge.

Test Plan:
1. Basic run, NBITS=4, golden=4'b1000:
   - Stimulus: pulse start, stream 1,0,0,0 with din_valid=1.
   - Required: din_ready high exactly 4 cycles; sig sequence 0001, 0010, 0100, 1000.
   - Required: done=1 and pass=1 on edge 6 after the start edge; busy then 0.
2. Mismatch and wrap through feedback, NBITS=5, golden=4'b1000:
   - Stimulus: stream 1,0,0,0,0.
   - Required: final sig=4'b0011, done=1, pass=0.
3. Stalls, NBITS=4:
   - Stimulus: stream of scenario 1 with din_valid low for 3 cycles between bits 2 and 3.
   - Required: sig holds 0010 during the stall; final sig=1000, pass=1; done delayed by exactly 3 cycles.
4. Abort and start-while-busy, NBITS=16:
   - Stimulus: after 5 accepted bits assert start (ignored), then assert abort.
   - Required: next edge state=IDLE, busy=0, done=0; a subsequent start begins with sig=0.
5. Async reset mid-SHIFT:
   - Stimulus: assert rst between clock edges.
   - Required: sig=0, done=0, pass=0, din_ready=0 immediately, without waiting for clk.
6. Default NBITS=16, golden=4'b0000:
   - Stimulus: all-zero stream.
   - Required: sig stays 0, done=1, pass=1.
   - Then restart immediately: done falls on the accepting edge.
